d_flipflop: RTL and testbench
=============================

D_FLIPFLOP -- requirements
Module: d_flipflop

Interface
REQ-001 Parameter WIDTH, default 1: number of independent storage bits, legal range 1..64.
REQ-002 Cp  input  1  clock; all synchronous capture occurs on the rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Sbar  input  1  asynchronous, active-low preset, applied to all bits.
REQ-005 Rbar  input  1  asynchronous, active-low clear, applied to all bits.
REQ-006 D  input  WIDTH  data captured on the rising edge of Cp.
REQ-007 Q  output  WIDTH  stored value.
REQ-008 Qbar  output  WIDTH  complement output; see REQ-015 for the one exception.
REQ-009 Conflict  output  1  high while Sbar=0 and Rbar=0 with Rst=0.
REQ-010 Ce  input  1  clock enable; this port exists only under D_FLIPFLOP_CE_EN (REQ-024).

Function
REQ-011 Priority, highest first: Rst; then Sbar=0 together with Rbar=0; then Rbar=0 alone; then Sbar=0 alone; then the clock edge.
REQ-012 With Rst=0, Sbar=1 and Rbar=1, each rising edge of Cp shall load Q<=D, with Qbar=~Q, one-edge latency.
REQ-013 Rbar=0 alone shall force Q=0 and Qbar=all-ones immediately, with no clock needed; D and Cp are ignored.
REQ-014 Sbar=0 alone shall force Q=all-ones and Qbar=0 immediately; D and Cp are ignored.
REQ-015 Sbar=0 and Rbar=0 together shall drive Q=all-ones and Qbar=all-ones (7474-style), assert Conflict=1, and set the internal state to 0.
REQ-016 On release of Sbar and/or Rbar, the outputs shall keep the value set by the async inputs until the next qualifying rising edge of Cp.
- After a simultaneous release from the conflict state, Q=0 and Qbar=all-ones.
REQ-017 A rising edge of Cp that coincides with any active async input shall be ignored; there shall be no capture on release.
REQ-018 Outside the conflict state, Q and Qbar shall always be bitwise complements.
REQ-019 All bits shall behave identically and independently for the data path; the async inputs act on all bits.
REQ-020 There shall be no X propagation from the async inputs: every defined input combination gives defined outputs.

Reset
REQ-021 Rst=1 shall force Q=0, Qbar=all-ones and Conflict=0 asynchronously, overriding Sbar, Rbar, Cp, D and Ce.
REQ-022 After Rst is deasserted, state shall hold until the next qualifying rising edge of Cp or an async set/clear.
- A Cp edge that coincides with Rst deassertion is ignored.
REQ-023 The power-up value is undefined until either Rst, Sbar or Rbar is applied or a qualifying clock edge occurs.

Configuration
REQ-024 Macro D_FLIPFLOP_CE_EN:
- When defined, port Ce is present and a rising edge loads D only when Ce=1; with Ce=0 the state holds.
- Ce does not gate the async inputs or Rst.
- When not defined, Ce is absent and every qualifying edge loads D.

Verification
Conditions for all scenarios: WIDTH=1, Cp period 100 ns, rising edges at 50 ns + n*100 ns.
REQ-025 Rst=1 pulse, then Rst=0 with Sbar=Rbar=1 -> Q=0 and Qbar=1 until the first edge.
REQ-026 Sbar=Rbar=1; D=0 for 0-100 ns, then D=1 for 100-200 ns -> Q=0 after the 50 ns edge, Q=1 and Qbar=0 after the 150 ns edge.
REQ-027 Walk {Sbar,Rbar,D} from 0 to 6, 25 ns per step, starting at 200 ns:
- Steps 0-1 (Sbar=Rbar=0): Q=1, Qbar=1, Conflict=1.
- Steps 2-3 (Sbar=0, Rbar=1): Q=1, Qbar=0 immediately, not at a clock edge.
- Steps 4-5 (Sbar=1, Rbar=0): Q=0, Qbar=1 immediately.
- Step 6 (Sbar=Rbar=1, D=0): Q holds at 0, then the edge at 350 ns loads D=0.
REQ-028 Sbar=Rbar=0 held, then both released simultaneously -> Q=0, Qbar=1, Conflict=0; the next edge with D=1 gives Q=1.
REQ-029 Rst=1 asserted mid-cycle while Sbar=0 -> Q=0 and Qbar=1 at once; Rst released with Sbar=1 -> state held until the next edge.
REQ-030 With D_FLIPFLOP_CE_EN defined: Ce=0 with D=1 over two edges -> Q stays 0; Ce=1 -> Q=1 after the next edge.

Source files
------------

// File: rtl/d_flipflop.sv
// WIDTH-bit D flip-flop with async reset, active-low preset/clear and a 7474-style conflict state.
// Optional clock enable port Ce is present when D_FLIPFLOP_CE_EN is defined.
module d_flipflop #(
  parameter int WIDTH = 1
) (
  input  logic             Cp,
  input  logic             Rst,
  input  logic             Sbar,
  input  logic             Rbar,
`ifdef D_FLIPFLOP_CE_EN
  input  logic             Ce,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             Conflict
);

  logic [WIDTH-1:0] state;
  logic             both_low;

  assign both_low = ~Sbar & ~Rbar;

  // Conflict and clear both leave the stored value at 0, so a simultaneous
  // release from conflict reads back as Q=0.
  always_ff @(posedge Cp or posedge Rst or negedge Sbar or negedge Rbar) begin
    if (Rst) begin
      state <= '0;
    end else if (!Sbar && !Rbar) begin
      state <= '0;
    end else if (!Rbar) begin
      state <= '0;
    end else if (!Sbar) begin
      state <= '1;
`ifdef D_FLIPFLOP_CE_EN
    end else if (Ce) begin
      state <= D;
`else
    end else begin
      state <= D;
`endif
    end
  end

  // Outputs follow the async inputs directly so the forced value is visible
  // at once, independent of which async edge last updated the register.
  always_comb begin
    Q        = state;
    Qbar     = ~state;
    Conflict = 1'b0;
    if (Rst) begin
      Q    = '0;
      Qbar = '1;
    end else if (both_low) begin
      Q        = '1;
      Qbar     = '1;
      Conflict = 1'b1;
    end else if (!Rbar) begin
      Q    = '0;
      Qbar = '1;
    end else if (!Sbar) begin
      Q    = '1;
      Qbar = '0;
    end
  end

endmodule

// File: tb/tb_d_flipflop.sv
// Directed-vector bench for d_flipflop (WIDTH=1, Cp rising at 50 ns + n*100 ns).
`timescale 1ns/1ps
module tb_d_flipflop;

  logic       Cp;
  logic       Rst;
  logic       Sbar;
  logic       Rbar;
  logic       Ce;
  logic [0:0] D;
  logic [0:0] Q;
  logic [0:0] Qbar;
  logic       Conflict;

  int total = 0;
  int bad   = 0;

  d_flipflop #(.WIDTH(1)) dut (
    .Cp       (Cp),
    .Rst      (Rst),
    .Sbar     (Sbar),
    .Rbar     (Rbar),
`ifdef D_FLIPFLOP_CE_EN
    .Ce       (Ce),
`endif
    .D        (D),
    .Q        (Q),
    .Qbar     (Qbar),
    .Conflict (Conflict)
  );

  initial begin
    Cp = 1'b0;
    forever #50 Cp = ~Cp;
  end

  task automatic at(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Compares {Q, Qbar, Conflict} against a hand-computed expectation.
  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {Q, Qbar, Conflict};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s at %0t: observed {Q,Qbar,Conflict}=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  initial begin
    Ce   = 1'b1;
    Rst  = 1'b1;
    Sbar = 1'b1;
    Rbar = 1'b1;
    D    = 1'b0;

    at(10);  chk("reset_active", 3'b010);
    at(20);  Rst = 1'b0;
    at(30);  chk("post_reset_hold", 3'b010);

    at(60);  chk("edge50_d0", 3'b010);
    at(100); D = 1'b1;
    at(110); chk("latency_before_edge", 3'b010);
    at(160); chk("edge150_d1", 3'b100);

    // Walk {Sbar,Rbar,D} 0..6, 25 ns per step from 200 ns
    at(200); {Sbar, Rbar, D} = 3'd0;
    at(201); chk("walk0_conflict", 3'b111);
    at(225); {Sbar, Rbar, D} = 3'd1;
    at(226); chk("walk1_conflict", 3'b111);
    at(250); {Sbar, Rbar, D} = 3'd2;
    at(262); chk("walk2_preset", 3'b100);
    at(275); {Sbar, Rbar, D} = 3'd3;
    at(276); chk("walk3_preset", 3'b100);
    at(300); {Sbar, Rbar, D} = 3'd4;
    at(301); chk("walk4_clear_now", 3'b010);
    at(325); {Sbar, Rbar, D} = 3'd5;
    at(326); chk("walk5_clear", 3'b010);
    at(350); {Sbar, Rbar, D} = 3'd6;
    at(351); chk("walk6_release", 3'b010);
    at(360); D = 1'b1;
    at(440); chk("hold_after_release", 3'b010);
    at(460); chk("edge450_d1", 3'b100);

    // Simultaneous release from conflict
    at(470); Sbar = 1'b0; Rbar = 1'b0;
    at(471); chk("conflict_hold", 3'b111);
    at(500); Sbar = 1'b1; Rbar = 1'b1;
    at(501); chk("conflict_release", 3'b010);
    at(560); chk("edge550_after_conflict", 3'b100);

    // Reset mid-cycle while preset is active
    at(570); Sbar = 1'b0;
    at(571); chk("preset_before_rst", 3'b100);
    at(600); Rst = 1'b1;
    at(601); chk("rst_over_preset", 3'b010);
    at(610); Rbar = 1'b0;
    at(611); chk("rst_over_conflict", 3'b010);
    at(615); Rbar = 1'b1;
    at(620); Sbar = 1'b1;
    at(630); Rst = 1'b0; D = 1'b1;
    at(640); chk("rst_release_hold", 3'b010);
    at(660); chk("edge650_after_rst", 3'b100);

    // Clear again, then data path with D=0
    at(670); Rbar = 1'b0;
    at(671); chk("clear_pulse", 3'b010);
    at(680); Rbar = 1'b1;
`ifdef D_FLIPFLOP_CE_EN
    Ce = 1'b0; D = 1'b1;
    at(860); chk("ce0_two_edges", 3'b010);
    Ce = 1'b1;
    at(960); chk("ce1_loads", 3'b100);
`else
    D = 1'b0;
    at(760); chk("edge750_d0", 3'b010);
    D = 1'b1;
    at(860); chk("edge850_d1", 3'b100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
